// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter, one bit per clock
// Optional leading-zero blank output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   sr, sr_nxt;
    logic [BCD_W-1:0]   work, work_nxt, corr;
    logic               acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               load_out;
    logic               accept;

    // Add-3 correction on every digit that would reach >= 10 after doubling.
    always_comb begin
        corr = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                corr[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        work_nxt  = work;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        load_out  = 1'b0;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    accept = 1'b1;
            end
            SHIFT: begin
                sr_nxt   = sr << 1;
                work_nxt = {corr[BCD_W-2:0], sr[BIN_W-1]};
                acc_nxt  = acc | corr[BCD_W-1];
                cnt_nxt  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    load_out  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = IDLE;
                    if (in_valid)
                        accept = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (accept) begin
            sr_nxt    = bin;
            work_nxt  = '0;
            acc_nxt   = 1'b0;
            cnt_nxt   = CNT_W'(BIN_W);
            state_nxt = SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            work  <= '0;
            acc   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            work  <= work_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Result registers only move on entry to DONE so SHIFT never disturbs the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            ovf <= 1'b0;
        end else if (load_out) begin
            bcd <= work_nxt;
            ovf <= acc_nxt;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    logic [DIGITS-1:0] blank_nxt;

    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_nxt  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (work_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blank <= BLANK_RST;
        else if (load_out)
            blank <= blank_nxt;
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (default and DIGITS=3 instances)
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
    logic [19:0] a_bin;
    logic [27:0] a_bcd;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
    logic [9:0]  b_bin;
    logic [11:0] b_bcd;

`ifdef BIN2BCD_BLANK_EN
    logic [6:0]  a_blank;
    logic [2:0]  b_blank;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(7)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .bin       (a_bin),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .bcd       (a_bcd),
        .ovf       (a_ovf)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank     (a_blank)
`endif
    );

    bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .bin       (b_bin),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .bcd       (b_bcd),
        .ovf       (b_ovf)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank     (b_blank)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_a(input logic [19:0] v);
        @(negedge clk);
        a_bin      = v;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack_a();
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic start_b(input logic [9:0] v);
        @(negedge clk);
        b_bin      = v;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack_b();
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    logic [19:0] va [4] = '{20'd9, 20'd10, 20'd999999, 20'd524288};
    logic [27:0] ea [4] = '{28'h0000009, 28'h0000010, 28'h0999999, 28'h0524288};

    logic [9:0]  vb  [4] = '{10'd1000, 10'd999, 10'd1023, 10'd5};
    logic [11:0] eb  [4] = '{12'h000, 12'h999, 12'h023, 12'h005};
    logic        eob [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  ebl [4] = '{3'b110, 3'b000, 3'b100, 3'b110};

    initial begin
        int lat;
        int gap;
        int seen;

        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_bin       = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_bin       = '0;

        repeat (3) @(negedge clk);
        check("rst_bcd", a_bcd, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_b_in_ready", b_in_ready, 1);
`ifdef BIN2BCD_BLANK_EN
        check("rst_blank", a_blank, 7'b1111110);
        check("rst_b_blank", b_blank, 3'b110);
`endif
        rst_n = 1'b1;

        start_a(20'd0);
        check("shift_in_ready", a_in_ready, 0);
        wait_a(lat);
        check("zero_latency", lat, 20);
        check("zero_bcd", a_bcd, 28'h0000000);
        check("zero_ovf", a_ovf, 0);
`ifdef BIN2BCD_BLANK_EN
        check("zero_blank", a_blank, 7'b1111110);
`endif
        ack_a();
        check("idle_out_valid", a_out_valid, 0);
        check("idle_in_ready", a_in_ready, 1);

        for (int i = 0; i < 4; i++) begin
            start_a(va[i]);
            wait_a(lat);
            check($sformatf("tab%0d_latency", i), lat, 20);
            check($sformatf("tab%0d_bcd", i), a_bcd, ea[i]);
            check($sformatf("tab%0d_ovf", i), a_ovf, 0);
            ack_a();
        end

        start_a(20'hFFFFF);
        wait_a(lat);
        check("max_bcd", a_bcd, 28'h1048575);
        check("max_ovf", a_ovf, 0);
        a_bin       = 20'd12345;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        #1;
        check("fast_in_ready", a_in_ready, 1);
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        gap = 1;
        check("fast_shift_out_valid", a_out_valid, 0);
        check("fast_held_bcd", a_bcd, 28'h1048575);
        while (!a_out_valid && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("fast_gap", gap, 21);
        check("fast_bcd", a_bcd, 28'h0012345);
        check("fast_ovf", a_ovf, 0);

        a_bin      = 20'd555;
        a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", i), a_out_valid, 1);
            check($sformatf("bp%0d_in_ready", i), a_in_ready, 0);
            check($sformatf("bp%0d_bcd", i), a_bcd, 28'h0012345);
            check($sformatf("bp%0d_ovf", i), a_ovf, 0);
        end
        a_in_valid = 1'b0;
        ack_a();
        check("bp_release_out_valid", a_out_valid, 0);
        check("bp_release_in_ready", a_in_ready, 1);
        check("bp_release_bcd", a_bcd, 28'h0012345);

        start_a(20'd777);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_bcd", a_bcd, 0);
        check("midrst_in_ready", a_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("midrst_no_out_valid", seen, 0);

        start_a(20'd42);
        wait_a(lat);
        check("after_rst_latency", lat, 20);
        check("after_rst_bcd", a_bcd, 28'h0000042);
        check("after_rst_ovf", a_ovf, 0);
`ifdef BIN2BCD_BLANK_EN
        check("after_rst_blank", a_blank, 7'b1111100);
`endif
        ack_a();

        for (int i = 0; i < 4; i++) begin
            start_b(vb[i]);
            wait_b(lat);
            check($sformatf("b%0d_latency", i), lat, 10);
            check($sformatf("b%0d_bcd", i), b_bcd, eb[i]);
            check($sformatf("b%0d_ovf", i), b_ovf, eob[i]);
`ifdef BIN2BCD_BLANK_EN
            check($sformatf("b%0d_blank", i), b_blank, ebl[i]);
`endif
            ack_b();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
